// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the instruction-fetch stage: D register layout,
// instruction-bus request/response bundles, fetch FSM states.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        GOT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imp;
        logic        adel;
    } D_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding ibus request, 1-entry return buffer, D register.
// Latency: D loads on the edge after data_ok (bypass), so 1 cycle/instr only with same-cycle addr_ok/data_ok.
// Backpressure: stall holds D; a returning word parks in the buffer and no new request is issued.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_adel
);

    fetch_state_t state, state_nxt;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    D_type        d_q;

    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic [31:0] buf_instr;
    logic [31:0] word;
    logic        redir_pending;
    logic [31:0] redir_target;
    logic        misaligned;
    logic        word_avail;
    logic        transfer;

    assign iresp      = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};
    assign misaligned = |fetch_pc[1:0];

    // A misaligned PC never reaches the bus; it behaves as an already-fetched NOP.
    always_comb begin
        word_avail = 1'b0;
        word       = buf_instr;
        case (state)
            REQ: begin
                if (misaligned) begin
                    word_avail = 1'b1;
                    word       = 32'd0;
                end else begin
                    word_avail = iresp.addr_ok & iresp.data_ok;
                    word       = iresp.data;
                end
            end
            WAIT: begin
                word_avail = iresp.data_ok;
                word       = iresp.data;
            end
            GOT: begin
                word_avail = 1'b1;
                word       = buf_instr;
            end
            default: begin
                word_avail = 1'b0;
                word       = buf_instr;
            end
        endcase
    end

    assign transfer = word_avail & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (transfer) begin
            state_nxt = REQ;
        end else if (word_avail) begin
            state_nxt = GOT;
        end else if (state == REQ && !misaligned && iresp.addr_ok) begin
            state_nxt = WAIT;
        end
    end

    always_comb begin
        ireq.valid = (state == REQ) & ~misaligned & ~reset;
        ireq.addr  = fetch_pc;
    end

    assign ireq_valid = ireq.valid;
    assign ireq_addr  = ireq.addr;

    // Redirect in the transfer cycle means the word leaving now is the delay slot.
    always_comb begin
        if (redirect && !stall) begin
            next_pc = redirect_pc;
        end else if (redir_pending) begin
            next_pc = redir_target;
        end else begin
            next_pc = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            buf_instr     <= 32'd0;
            redir_pending <= 1'b0;
            redir_target  <= 32'd0;
        end else begin
            if (transfer) begin
                fetch_pc      <= next_pc;
                redir_pending <= 1'b0;
            end else if (redirect && !stall) begin
                redir_pending <= 1'b1;
                redir_target  <= redirect_pc;
            end
            if (word_avail && !transfer) begin
                buf_instr <= word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
        end else if (!stall) begin
            if (transfer) begin
                d_q <= '{valid: 1'b1, pc: fetch_pc, imp: word, adel: misaligned};
            end else begin
                d_q <= '0;
            end
        end
    end

    assign d_valid = d_q.valid;
    assign d_pc    = d_q.pc;
    assign d_instr = d_q.imp;
    assign d_adel  = d_q.adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle table for fetch_stage against a simple instruction-bus responder
// (lat=0: same-cycle addr_ok/data_ok, lat=N: data_ok N cycles after addr_ok).
module tb_fetch_stage;

    localparam logic [31:0] B = 32'hbfc0_0000;
    localparam logic [31:0] K = 32'h5a5a_0f0f;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_adel;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int cnt;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_adel(d_adel)
    );

    always @* begin
        iresp_addr_ok = ireq_valid;
        if (lat == 0) begin
            iresp_data_ok = ireq_valid;
            iresp_data    = ireq_valid ? (ireq_addr ^ K) : 32'd0;
        end else begin
            iresp_data_ok = (cnt == 1);
            iresp_data    = (cnt == 1) ? (pend_addr ^ K) : 32'd0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 0;
            pend_addr <= 32'd0;
        end else if (lat != 0 && ireq_valid) begin
            cnt       <= lat;
            pend_addr <= ireq_addr;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    typedef struct {
        int          lat;
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        eiv;
        logic [31:0] eaddr;
        logic        edv;
        logic [31:0] epc;
        logic        eadel;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int l, input logic r, input logic s, input logic rd,
                       input logic [31:0] rp, input logic eiv, input logic [31:0] ea,
                       input logic edv, input logic [31:0] ep, input logic eadel);
        vec_t v;
        v = '{lat: l, rst: r, stall: s, redir: rd, rpc: rp, eiv: eiv, eaddr: ea,
              edv: edv, epc: ep, eadel: eadel};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic eiv, input logic [31:0] ea,
                               input logic edv, input logic [31:0] ep, input logic eadel);
        logic [31:0] einstr;
        einstr = (edv && !eadel) ? (ep ^ K) : 32'd0;
        chk({tag, ".ireq_valid"}, {31'd0, ireq_valid}, {31'd0, eiv});
        if (eiv) chk({tag, ".ireq_addr"}, ireq_addr, ea);
        chk({tag, ".d_valid"}, {31'd0, d_valid}, {31'd0, edv});
        chk({tag, ".d_pc"}, d_pc, ep);
        chk({tag, ".d_instr"}, d_instr, einstr);
        chk({tag, ".d_adel"}, {31'd0, d_adel}, {31'd0, eadel});
    endtask

    initial begin
        // same-cycle memory: streaming, stall into buffer, bypass redirect, misaligned
        add(0, 1, 0, 0, 0,        0, 0,        0, 0,        0);
        add(0, 0, 0, 0, 0,        1, B,        0, 0,        0);
        add(0, 0, 0, 0, 0,        1, B+4,      1, B,        0);
        add(0, 0, 0, 0, 0,        1, B+8,      1, B+4,      0);
        add(0, 0, 1, 0, 0,        1, B+'h0c,   1, B+8,      0);
        add(0, 0, 1, 0, 0,        0, 0,        1, B+8,      0);
        add(0, 0, 1, 0, 0,        0, 0,        1, B+8,      0);
        add(0, 0, 1, 0, 0,        0, 0,        1, B+8,      0);
        add(0, 0, 0, 0, 0,        0, 0,        1, B+8,      0);
        add(0, 0, 0, 0, 0,        1, B+'h10,   1, B+'h0c,   0);
        add(0, 0, 0, 1, B+'h100,  1, B+'h14,   1, B+'h10,   0);
        add(0, 0, 0, 0, 0,        1, B+'h100,  1, B+'h14,   0);
        add(0, 0, 0, 1, B+'h102,  1, B+'h104,  1, B+'h100,  0);
        add(0, 0, 0, 0, 0,        0, 0,        1, B+'h104,  0);
        add(0, 0, 0, 1, B,        0, 0,        1, B+'h102,  1);
        add(0, 0, 0, 0, 0,        1, B,        1, B+'h106,  1);
        add(0, 0, 0, 0, 0,        1, B+4,      1, B,        0);
        // 3-cycle memory: WAIT bubbles, redirect while delay slot is in flight, reset mid-WAIT
        add(3, 1, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        1, B,        0, 0,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 1, B+'h100,  1, B+4,      1, B,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(3, 0, 0, 0, 0,        1, B+'h100,  1, B+4,      0);
        add(3, 0, 0, 0, 0,        0, 0,        0, 0,        0);
        add(0, 1, 0, 0, 0,        0, 0,        0, 0,        0);
        add(0, 0, 0, 0, 0,        1, B,        0, 0,        0);
        add(0, 0, 0, 0, 0,        1, B+4,      1, B,        0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            lat         = vq[i].lat;
            reset       = vq[i].rst;
            stall       = vq[i].stall;
            redirect    = vq[i].redir;
            redirect_pc = vq[i].rpc;
            #1;
            chk_outputs($sformatf("row%0d", i), vq[i].eiv, vq[i].eaddr,
                        vq[i].edv, vq[i].epc, vq[i].eadel);
        end

        // Hand sequence: slow word returns while stalled, parks in buffer, drains on release.
        @(negedge clk);
        reset = 1'b1; lat = 3; stall = 1'b1; redirect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_outputs("hs_c0", 1'b1, B, 1'b0, 32'd0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            #1;
            chk_outputs($sformatf("hs_c%0d", c), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk_outputs("hs_release", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        chk_outputs("hs_drain", 1'b1, B+4, 1'b1, B, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
